// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding and ALU codes for the multi-cycle control unit.
// Instruction classification helper used by the controller decode logic.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ALU_ADD  = 4'h0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        C_R,
        C_ADDI,
        C_LW,
        C_SW,
        C_J,
        C_HALT,
        C_ILL
    } iclass_t;

    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t c;
        unique case (1'b1)
            op == OP_RTYPE: c = C_R;
            op == OP_ADDI:  c = C_ADDI;
            op == OP_LW:    c = C_LW;
            op == OP_SW:    c = C_SW;
            op == OP_J:     c = C_J;
            op == OP_HALT:  c = C_HALT;
            default:        c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// 8-bit wait counter for req/ack handshakes.
// expired_o flags the waiting cycle that brings the count to LIMIT.
module ack_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle main control: FETCH/DECODE/EXEC/MEM/WB over req/ack memory ports.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into ERR (else they are NOPs).
module control_multiciclo
    import ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        i_req,
    input  logic        i_ack,
    output logic        d_req,
    output logic        d_we,
    input  logic        d_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        pc_src,
    output logic        sel_ext,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        bus_err,
    output logic        ill_op
);

    state_t  state_q;
    state_t  state_d;
    iclass_t cls;

    logic i_req_q;
    logic d_req_q;
    logic d_we_q;
    logic halted_q;
    logic bus_err_q;
    logic fetch_ack;
    logic mem_ack;
    logic waiting;
    logic tmo;
    logic unused_instr;

    assign cls          = classify(instr[31:26]);
    assign unused_instr = ^instr[25:4];

    // Acks only count while the matching request is actually out.
    assign fetch_ack = i_req_q & i_ack;
    assign mem_ack   = d_req_q & d_ack;
    assign waiting   = (i_req_q & ~i_ack) | (d_req_q & ~d_ack);

    ack_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (~waiting),
        .en_i     (waiting),
        .expired_o(tmo)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (fetch_ack) begin
                    state_d = DECODE;
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            DECODE: begin
                unique case (cls)
                    C_HALT:  state_d = HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    C_ILL:   state_d = ERR;
`else
                    C_ILL:   state_d = FETCH;
`endif
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                unique case (cls)
                    C_J:        state_d = FETCH;
                    C_LW, C_SW: state_d = MEM;
                    default:    state_d = WB;
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = (cls == C_LW) ? WB : FETCH;
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            WB:      state_d = FETCH;
            default: state_d = state_q;
        endcase
    end

    // Requests are registered so they stay low during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            i_req_q   <= 1'b0;
            d_req_q   <= 1'b0;
            d_we_q    <= 1'b0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_req_q   <= (state_d == FETCH);
            d_req_q   <= (state_d == MEM);
            d_we_q    <= (state_d == MEM) && (cls == C_SW);
            halted_q  <= halted_q | (state_d == HALT);
            bus_err_q <= bus_err_q | tmo;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_op_q <= 1'b0;
        end else if ((state_q == DECODE) && (cls == C_ILL)) begin
            ill_op_q <= 1'b1;
        end
    end

    assign ill_op = ill_op_q;
`else
    assign ill_op = 1'b0;
`endif

    assign i_req   = i_req_q;
    assign d_req   = d_req_q;
    assign d_we    = d_we_q;
    assign halted  = halted_q;
    assign bus_err = bus_err_q;

    always_comb begin
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = 1'b0;
        sel_ext    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        unique case (state_q)
            FETCH: begin
                ir_we = fetch_ack;
                pc_we = fetch_ack;
            end
            EXEC: begin
                unique case (cls)
                    C_R: begin
                        alu_op  = instr[3:0];
                        reg_dst = 1'b1;
                    end
                    C_ADDI, C_LW, C_SW: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                    end
                    C_J: begin
                        sel_ext = 1'b1;
                        pc_src  = 1'b1;
                        pc_we   = 1'b1;
                    end
                    default: ;
                endcase
            end
            WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (cls == C_LW);
                reg_dst    = (cls == C_R);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: table vectors, corner sequences and a
// random instruction stream checked against a per-cycle schedule model.
module tb_control_multiciclo;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic        ir_we, pc_we, reg_we, pc_src, sel_ext, alu_src;
    logic [3:0]  alu_op;
    logic        reg_dst, mem_to_reg, halted, bus_err, ill_op;

    control_multiciclo #(.ACK_TIMEOUT(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .i_req     (i_req),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_ack     (d_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .pc_src    (pc_src),
        .sel_ext   (sel_ext),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .halted    (halted),
        .bus_err   (bus_err),
        .ill_op    (ill_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       i_req, d_req, d_we, ir_we, pc_we, reg_we;
        logic       pc_src, sel_ext, alu_src;
        logic [3:0] alu_op;
        logic       reg_dst, mem_to_reg, halted, bus_err, ill_op;
    } outs_t;

    outs_t got;
    assign got = {i_req, d_req, d_we, ir_we, pc_we, reg_we, pc_src, sel_ext,
                  alu_src, alu_op, reg_dst, mem_to_reg, halted, bus_err, ill_op};

    typedef struct {
        bit    ia, da, ia_rnd, da_rnd;
        outs_t e;
    } cyc_t;

    typedef struct {
        logic [31:0] w;
        int          iw, dw, cyc;
        logic [3:0]  aop;
        bit          rw;
    } vec_t;

    cyc_t sq[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   scyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input outs_t e, input bit ia, input bit da, input bit ir, input bit dr);
        cyc_t c;
        c.e = e; c.ia = ia; c.da = da; c.ia_rnd = ir; c.da_rnd = dr;
        sq.push_back(c);
    endtask

    // Expected per-cycle outputs of one instruction, from the opcode rules.
    task automatic model_instr(input logic [31:0] w, input int iw, input int dw);
        logic [5:0] op;
        outs_t z, e;
        op = w[31:26];
        z = '0;
        for (int k = 0; k < iw; k++) begin
            e = z; e.i_req = 1; push(e, 0, 0, 0, 1);
        end
        e = z; e.i_req = 1; e.ir_we = 1; e.pc_we = 1; push(e, 1, 0, 0, 1);
        push(z, 0, 0, 1, 1);
        if (op == 6'h00) begin
            e = z; e.alu_op = w[3:0]; e.reg_dst = 1; push(e, 0, 0, 1, 1);
            e = z; e.reg_we = 1; e.reg_dst = 1; push(e, 0, 0, 1, 1);
        end else if (op == 6'h08) begin
            e = z; e.alu_src = 1; push(e, 0, 0, 1, 1);
            e = z; e.reg_we = 1; push(e, 0, 0, 1, 1);
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = z; e.alu_src = 1; push(e, 0, 0, 1, 1);
            e = z; e.d_req = 1; e.d_we = (op == 6'h2B);
            for (int k = 0; k < dw; k++) push(e, 0, 0, 1, 0);
            push(e, 0, 1, 1, 0);
            if (op == 6'h23) begin
                e = z; e.reg_we = 1; e.mem_to_reg = 1; push(e, 0, 0, 1, 1);
            end
        end else if (op == 6'h02) begin
            e = z; e.sel_ext = 1; e.pc_src = 1; e.pc_we = 1; push(e, 0, 0, 1, 1);
        end
    endtask

    task automatic run_stream();
        cyc_t c;
        while (sq.size() > 0) begin
            c = sq.pop_front();
            i_ack = c.ia_rnd ? 1'($urandom & 1) : c.ia;
            d_ack = c.da_rnd ? 1'($urandom & 1) : c.da;
            #1;
            checks++;
            if (got !== c.e) begin
                failures++;
                $display("FAIL stream_cycle%0d actual=%h required=%h", scyc, got, c.e);
            end
            scyc++;
            @(negedge clk);
        end
        i_ack = 0; d_ack = 0;
    endtask

    task automatic run_measured(input logic [31:0] w, input int iw, input int dw,
                                output int n, output logic [3:0] aop, output bit rw);
        int ic, dc;
        bit fetched;
        ic = 0; dc = 0; fetched = 0; n = 0; aop = 0; rw = 0;
        instr = w;
        while (n < 40) begin
            if (fetched && i_req) break;
            i_ack = i_req && (ic == iw);
            d_ack = d_req && (dc == dw);
            #1;
            if (ir_we) fetched = 1;
            aop |= alu_op;
            rw  |= reg_we;
            if (i_req && !i_ack) ic++;
            if (d_req && !d_ack) dc++;
            n++;
            @(negedge clk);
        end
        i_ack = 0; d_ack = 0;
    endtask

    task automatic count_req(input bit use_d, output int n);
        n = 0;
        while (n < 300) begin
            if (!(use_d ? d_req : i_req)) break;
            i_ack = 0; d_ack = 0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; i_ack = 0; d_ack = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic rand_cycles(input int k);
        for (int j = 0; j < k; j++) begin
            i_ack = 1'($urandom & 1);
            d_ack = 1'($urandom & 1);
            @(negedge clk);
        end
        i_ack = 0; d_ack = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    logic [5:0] ill_ops [4] = '{6'h3E, 6'h01, 6'h10, 6'h2A};

    initial begin
        int n;
        logic [3:0] aop;
        bit rw;
        logic [31:0] w;
        logic [5:0] op;
        int pick;

        rst_n = 1; i_ack = 0; d_ack = 0; instr = '0;
        #2 rst_n = 0;
        #1 chk("reset_outputs", got, 0);
        @(negedge clk);
        #1 chk("reset_hold", got, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("i_req_at_release", i_req, 0);
        @(negedge clk);
        chk("i_req_first_cycle", i_req, 1);

        tbl.push_back('{32'h0000_0003, 0, 0, 4, 4'h3, 1});
        tbl.push_back('{32'h0BFF_FFFF, 0, 0, 3, 4'h0, 0});
        tbl.push_back('{32'h8C00_0000, 0, 3, 8, 4'h0, 1});
        tbl.push_back('{32'hAC00_0000, 0, 0, 4, 4'h0, 0});
        tbl.push_back('{32'h2000_0000, 2, 0, 6, 4'h0, 1});
        tbl.push_back('{32'h0000_000F, 1, 0, 5, 4'hF, 1});
        tbl.push_back('{32'h8C00_0000, 0, 0, 5, 4'h0, 1});
        tbl.push_back('{32'hAC00_0000, 1, 2, 7, 4'h0, 0});
`ifndef CTRL_ILLEGAL_TRAP_EN
        tbl.push_back('{32'hF800_0000, 0, 0, 2, 4'h0, 0});
`endif
        foreach (tbl[i]) begin
            run_measured(tbl[i].w, tbl[i].iw, tbl[i].dw, n, aop, rw);
            chk($sformatf("vec%0d_cycles", i), n, tbl[i].cyc);
            chk($sformatf("vec%0d_alu_op", i), aop, tbl[i].aop);
            chk($sformatf("vec%0d_reg_we", i), rw, tbl[i].rw);
        end

        do_reset();
        instr = 32'hFC00_0000;
        i_ack = 1;
        @(negedge clk);
        i_ack = 0;
        #1 chk("halt_decode_flag", halted, 0);
        @(negedge clk);
        #1 chk("halt_flag", halted, 1);
        chk("halt_no_req", i_req, 0);
        rand_cycles(5);
        chk("halt_sticky", halted, 1);
        chk("halt_quiet", {i_req, d_req, reg_we, ir_we}, 0);

        do_reset();
        instr = 32'h0000_0001;
        count_req(0, n);
        chk("ifetch_timeout_cycles", n, 255);
        #1 chk("ifetch_bus_err", bus_err, 1);
        rand_cycles(3);
        chk("ifetch_err_sticky", bus_err, 1);
        chk("ifetch_err_no_req", i_req, 0);

        do_reset();
        instr = 32'h0000_0001;
        for (int k = 0; k < 254; k++) begin
            i_ack = 0;
            @(negedge clk);
        end
        i_ack = 1;
        #1 chk("ack_wins_ir_we", ir_we, 1);
        @(negedge clk);
        i_ack = 0;
        #1 chk("ack_wins_no_err", bus_err, 0);
        chk("ack_wins_left_fetch", i_req, 0);

        do_reset();
        instr = 32'hAC00_0000;
        i_ack = 1;
        @(negedge clk);
        i_ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk("sw_d_we", d_we, 1);
        count_req(1, n);
        chk("mem_timeout_cycles", n, 255);
        #1 chk("mem_bus_err", bus_err, 1);
        rand_cycles(2);
        chk("mem_err_no_req", d_req, 0);

        do_reset();
        instr = 32'h8C00_0000;
        i_ack = 1;
        @(negedge clk);
        i_ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk("lw_pending_d_req", {d_req, d_we}, 2'b10);
        #2 rst_n = 0;
        #1 chk("async_reset_outputs", got, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("async_release_req_low", i_req, 0);
        @(negedge clk);
        chk("fetch_resumes", i_req, 1);
        run_measured(32'h0000_0005, 0, 0, n, aop, rw);
        chk("post_reset_rtype_cycles", n, 4);

`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset();
        instr = 32'hF800_0000;
        i_ack = 1;
        @(negedge clk);
        i_ack = 0;
        #1 chk("ill_decode_flag", ill_op, 0);
        @(negedge clk);
        #1 chk("ill_op_flag", ill_op, 1);
        rand_cycles(4);
        chk("ill_no_req", i_req, 0);
        chk("ill_sticky", ill_op, 1);
`endif

        do_reset();
        for (int t = 0; t < 200; t++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            pick = $urandom % 5;
`else
            pick = $urandom % 6;
`endif
            case (pick)
                0:       op = 6'h00;
                1:       op = 6'h08;
                2:       op = 6'h23;
                3:       op = 6'h2B;
                4:       op = 6'h02;
                default: op = ill_ops[$urandom % 4];
            endcase
            w = $urandom;
            w[31:26] = op;
            instr = w;
            model_instr(w, $urandom % 4, $urandom % 4);
            run_stream();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
